// File: rtl/poly_note_alloc_pkg.sv
// Shared types for the polyphonic note allocator: note constants, voice state
// encoding and the ASCII key-code to note-index map.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package poly_note_alloc_pkg;

  localparam int NOTE_W = 5;
  localparam int CNT_W  = 8;

  // Note indices: Z..M = 0..6, A..J = 7..13, Q..U = 14..20, 21 = rest.
  localparam logic [NOTE_W-1:0] NOTE_LOW_FIRST = 5'd0;
  localparam logic [NOTE_W-1:0] NOTE_MID_FIRST = 5'd7;
  localparam logic [NOTE_W-1:0] NOTE_TOP_FIRST = 5'd14;
  localparam logic [NOTE_W-1:0] NOTE_REST      = 5'd21;

  typedef enum logic [1:0] {
    VS_IDLE = 2'd0,
    VS_GATE = 2'd1,
    VS_REL  = 2'd2
  } voice_state_t;

  typedef struct packed {
    logic              hit;
    logic [NOTE_W-1:0] note;
  } key_lookup_t;

  // Uppercase ASCII only, as delivered by the keyboard decoder.
  function automatic key_lookup_t key_to_note(input logic [7:0] code);
    key_lookup_t r;
    r.hit  = 1'b1;
    r.note = NOTE_REST;
    case (code)
      8'h5A: r.note = NOTE_LOW_FIRST + 5'd0;  // Z
      8'h58: r.note = NOTE_LOW_FIRST + 5'd1;  // X
      8'h43: r.note = NOTE_LOW_FIRST + 5'd2;  // C
      8'h56: r.note = NOTE_LOW_FIRST + 5'd3;  // V
      8'h42: r.note = NOTE_LOW_FIRST + 5'd4;  // B
      8'h4E: r.note = NOTE_LOW_FIRST + 5'd5;  // N
      8'h4D: r.note = NOTE_LOW_FIRST + 5'd6;  // M
      8'h41: r.note = NOTE_MID_FIRST + 5'd0;  // A
      8'h53: r.note = NOTE_MID_FIRST + 5'd1;  // S
      8'h44: r.note = NOTE_MID_FIRST + 5'd2;  // D
      8'h46: r.note = NOTE_MID_FIRST + 5'd3;  // F
      8'h47: r.note = NOTE_MID_FIRST + 5'd4;  // G
      8'h48: r.note = NOTE_MID_FIRST + 5'd5;  // H
      8'h4A: r.note = NOTE_MID_FIRST + 5'd6;  // J
      8'h51: r.note = NOTE_TOP_FIRST + 5'd0;  // Q
      8'h57: r.note = NOTE_TOP_FIRST + 5'd1;  // W
      8'h45: r.note = NOTE_TOP_FIRST + 5'd2;  // E
      8'h52: r.note = NOTE_TOP_FIRST + 5'd3;  // R
      8'h54: r.note = NOTE_TOP_FIRST + 5'd4;  // T
      8'h59: r.note = NOTE_TOP_FIRST + 5'd5;  // Y
      8'h55: r.note = NOTE_TOP_FIRST + 5'd6;  // U
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/poly_voice_slot.sv
// One voice slot: IDLE/GATE/REL state, held note, saturating age, release counter.
// Latency: commands sampled on inclk, new state visible the following cycle.
// Backpressure: none; every command is applied in the cycle it is presented.
// Ports: inclk/nCLR clock and sync active-low reset; take/take_note load a note
//   into GATE (allocate, steal or retrigger); rel_start enters REL; age_inc ages
//   an active voice; tick advances the release tail; state/note/age are the
//   slot's current contents.
module poly_voice_slot
  import poly_note_alloc_pkg::*;
#(
  parameter int                AGE_W         = 4,
  parameter int                RELEASE_TICKS = 8,
  parameter logic [NOTE_W-1:0] REST_NOTE     = 5'd21
) (
  input  logic              inclk,
  input  logic              nCLR,
  input  logic              take,
  input  logic [NOTE_W-1:0] take_note,
  input  logic              rel_start,
  input  logic              age_inc,
  input  logic              tick,
  output voice_state_t      state,
  output logic [NOTE_W-1:0] note,
  output logic [AGE_W-1:0]  age
);

  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};
  localparam logic [CNT_W-1:0] REL_LOAD = CNT_W'(RELEASE_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0]  rel_cnt;
  voice_state_t      state_nxt;
  logic [NOTE_W-1:0] note_nxt;
  logic [AGE_W-1:0]  age_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  always_ff @(posedge inclk) begin
    if (!nCLR) begin
      state   <= VS_IDLE;
      note    <= REST_NOTE;
      age     <= '0;
      rel_cnt <= '0;
    end else begin
      state   <= state_nxt;
      note    <= note_nxt;
      age     <= age_nxt;
      rel_cnt <= cnt_nxt;
    end
  end

  // Key events on this voice take precedence over a coincident tick.
  always_comb begin
    state_nxt = state;
    note_nxt  = note;
    age_nxt   = age;
    cnt_nxt   = rel_cnt;
    if (take) begin
      state_nxt = VS_GATE;
      note_nxt  = take_note;
      age_nxt   = '0;
      cnt_nxt   = '0;
    end else if (rel_start) begin
      state_nxt = VS_REL;
      cnt_nxt   = REL_LOAD;
    end else begin
      if (age_inc && (state != VS_IDLE) && (age != AGE_MAX)) begin
        age_nxt = age + 1'b1;
      end
      if (tick && (state == VS_REL)) begin
        if (rel_cnt <= CNT_ONE) begin
          state_nxt = VS_IDLE;
          note_nxt  = REST_NOTE;
          age_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = rel_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/poly_note_alloc.sv
// Polyphonic allocator: maps ASCII key press/release events onto NUM_VOICES voice slots.
// Latency: outputs update on the edge that samples key_valid/tick, visible next cycle.
// Backpressure: none; one key event per cycle is always accepted (unmapped codes dropped).
// Ports: inclk/nCLR clock and sync active-low reset; key_valid/key_code/key_release
//   key event; tick release-timing strobe; voice_note/voice_active/voice_gate per-voice
//   outputs (voice i note in bits [5i+4:5i]); last_note most recent press; steal pulse.
module poly_note_alloc
  import poly_note_alloc_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int RELEASE_TICKS = 8,
  parameter int AGE_W         = 4,
  parameter int REST_NOTE     = 21
) (
  input  logic                         inclk,
  input  logic                         nCLR,
  input  logic                         key_valid,
  input  logic [7:0]                   key_code,
  input  logic                         key_release,
  input  logic                         tick,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NOTE_W-1:0]            last_note,
  output logic                         steal
);

  localparam logic [NOTE_W-1:0] REST_N = NOTE_W'(REST_NOTE);

  key_lookup_t       lk;
  logic              press;
  logic              rel;

  voice_state_t      st [NUM_VOICES];
  logic [NOTE_W-1:0] nt [NUM_VOICES];
  logic [AGE_W-1:0]  ag [NUM_VOICES];

  logic [NUM_VOICES-1:0] take;
  logic [NUM_VOICES-1:0] rel_hit;
  logic [NUM_VOICES-1:0] age_inc;
  logic                  do_steal;

  int                    tgt;
  logic                  found_match;
  logic                  found_idle;
  logic                  found_rel;
  logic                  found_cand;
  logic [AGE_W-1:0]      best_age;

  assign lk    = key_to_note(key_code);
  assign press = key_valid & lk.hit & ~key_release;
  assign rel   = key_valid & lk.hit &  key_release;

  // Target selection: retrigger an existing voice, else lowest free voice,
  // else steal the oldest release-phase voice, else the oldest gated voice.
  always_comb begin
    tgt         = 0;
    found_match = 1'b0;
    found_idle  = 1'b0;
    found_rel   = 1'b0;
    found_cand  = 1'b0;
    best_age    = '0;
    take        = '0;
    rel_hit     = '0;
    age_inc     = '0;
    do_steal    = 1'b0;

    // Descending scan leaves the lowest matching index in tgt.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if ((st[i] != VS_IDLE) && (nt[i] == lk.note)) begin
        found_match = 1'b1;
        tgt         = i;
      end
    end
    if (!found_match) begin
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
        if (st[i] == VS_IDLE) begin
          found_idle = 1'b1;
          tgt        = i;
        end
      end
    end
    if (!found_match && !found_idle) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (st[i] == VS_REL) found_rel = 1'b1;
      end
      // Strict '>' keeps the lowest index on an age tie.
      for (int i = 0; i < NUM_VOICES; i++) begin
        if ((!found_rel || (st[i] == VS_REL)) && (!found_cand || (ag[i] > best_age))) begin
          found_cand = 1'b1;
          best_age   = ag[i];
          tgt        = i;
        end
      end
    end

    do_steal = press && !found_match && !found_idle;
    for (int i = 0; i < NUM_VOICES; i++) begin
      take[i]    = press && (tgt == i);
      age_inc[i] = press && (tgt != i);
      rel_hit[i] = rel && (st[i] == VS_GATE) && (nt[i] == lk.note);
    end
  end

  always_ff @(posedge inclk) begin
    if (!nCLR) begin
      last_note <= REST_N;
      steal     <= 1'b0;
    end else begin
      steal <= do_steal;
      if (press) last_note <= lk.note;
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    poly_voice_slot #(
      .AGE_W        (AGE_W),
      .RELEASE_TICKS(RELEASE_TICKS),
      .REST_NOTE    (REST_N)
    ) u_slot (
      .inclk    (inclk),
      .nCLR     (nCLR),
      .take     (take[g]),
      .take_note(lk.note),
      .rel_start(rel_hit[g]),
      .age_inc  (age_inc[g]),
      .tick     (tick),
      .state    (st[g]),
      .note     (nt[g]),
      .age      (ag[g])
    );

    assign voice_note[NOTE_W*g +: NOTE_W] = (st[g] == VS_IDLE) ? REST_N : nt[g];
    assign voice_active[g]                = (st[g] != VS_IDLE);
    assign voice_gate[g]                  = (st[g] == VS_GATE);
  end

endmodule

// File: tb/tb_poly_note_alloc.sv
// Directed bench for poly_note_alloc (4 voices, 8 release ticks, 4-bit ages).
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_poly_note_alloc;

  logic        inclk = 1'b0;
  logic        nCLR = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = 8'h00;
  logic        key_release = 1'b0;
  logic        tick = 1'b0;
  logic [19:0] voice_note;
  logic [3:0]  voice_active;
  logic [3:0]  voice_gate;
  logic [4:0]  last_note;
  logic        steal;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] R = 5'd21;

  poly_note_alloc #(
    .NUM_VOICES(4), .RELEASE_TICKS(8), .AGE_W(4), .REST_NOTE(21)
  ) dut (
    .inclk(inclk), .nCLR(nCLR), .key_valid(key_valid), .key_code(key_code),
    .key_release(key_release), .tick(tick), .voice_note(voice_note),
    .voice_active(voice_active), .voice_gate(voice_gate), .last_note(last_note),
    .steal(steal)
  );

  always #5 inclk = ~inclk;

  // ---- stimulus helpers (start and end on a falling edge) ----
  task automatic do_reset();
    nCLR = 1'b0; key_valid = 1'b0; tick = 1'b0; key_release = 1'b0;
    repeat (2) @(negedge inclk);
    nCLR = 1'b1;
    @(negedge inclk);
  endtask

  task automatic key_ev(input logic [7:0] code, input logic is_rel, input logic tk);
    key_valid = 1'b1; key_code = code; key_release = is_rel; tick = tk;
    @(negedge inclk);
    key_valid = 1'b0; key_release = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge inclk);
    tick = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    do_reset();
    checks++; if (voice_note !== {R, R, R, R}) begin errors++; $display("FAIL reset_note: got %h want %h", voice_note, {R, R, R, R}); end
    checks++; if (voice_active !== 4'b0000) begin errors++; $display("FAIL reset_active: got %b want 0000", voice_active); end
    checks++; if (voice_gate !== 4'b0000) begin errors++; $display("FAIL reset_gate: got %b want 0000", voice_gate); end
    checks++; if (last_note !== R) begin errors++; $display("FAIL reset_last: got %0d want 21", last_note); end
    checks++; if (steal !== 1'b0) begin errors++; $display("FAIL reset_steal: got %b want 0", steal); end
  endtask

  task automatic test_single_press();
    do_reset();
    key_ev(8'h41, 1'b0, 1'b0);  // A -> 7
    checks++; if (voice_note !== {R, R, R, 5'd7}) begin errors++; $display("FAIL press_note: got %h want %h", voice_note, {R, R, R, 5'd7}); end
    checks++; if (voice_gate !== 4'b0001) begin errors++; $display("FAIL press_gate: got %b want 0001", voice_gate); end
    checks++; if (last_note !== 5'd7) begin errors++; $display("FAIL press_last: got %0d want 7", last_note); end
  endtask

  task automatic test_steal_oldest();
    do_reset();
    key_ev(8'h41, 1'b0, 1'b0);  // A 7  -> v0
    key_ev(8'h53, 1'b0, 1'b0);  // S 8  -> v1
    key_ev(8'h44, 1'b0, 1'b0);  // D 9  -> v2
    key_ev(8'h46, 1'b0, 1'b0);  // F 10 -> v3
    checks++; if (steal !== 1'b0) begin errors++; $display("FAIL fill_steal: got %b want 0", steal); end
    key_ev(8'h47, 1'b0, 1'b0);  // G 11 steals v0 (age 3)
    checks++; if (voice_note !== {5'd10, 5'd9, 5'd8, 5'd11}) begin errors++; $display("FAIL steal_note: got %h want %h", voice_note, {5'd10, 5'd9, 5'd8, 5'd11}); end
    checks++; if (steal !== 1'b1) begin errors++; $display("FAIL steal_pulse: got %b want 1", steal); end
    checks++; if (last_note !== 5'd11) begin errors++; $display("FAIL steal_last: got %0d want 11", last_note); end
    @(negedge inclk);
    checks++; if (steal !== 1'b0) begin errors++; $display("FAIL steal_one_cycle: got %b want 0", steal); end
  endtask

  task automatic test_release_tail();
    do_reset();
    key_ev(8'h51, 1'b0, 1'b0);  // Q 14 -> v0
    key_ev(8'h51, 1'b1, 1'b0);
    checks++; if (voice_gate !== 4'b0000 || voice_active !== 4'b0001) begin errors++; $display("FAIL rel_enter: gate %b active %b want 0000/0001", voice_gate, voice_active); end
    for (int t = 1; t <= 7; t++) begin
      do_tick();
      checks++; if (voice_active !== 4'b0001) begin errors++; $display("FAIL rel_tick%0d: active %b want 0001", t, voice_active); end
    end
    do_tick();
    checks++; if (voice_active !== 4'b0000) begin errors++; $display("FAIL rel_done_active: got %b want 0000", voice_active); end
    checks++; if (voice_note !== {R, R, R, R}) begin errors++; $display("FAIL rel_done_note: got %h want %h", voice_note, {R, R, R, R}); end
  endtask

  task automatic test_steal_rel_pref();
    do_reset();
    key_ev(8'h41, 1'b0, 1'b0);  // v0=7  ages end 3
    key_ev(8'h53, 1'b0, 1'b0);  // v1=8  ages end 2
    key_ev(8'h44, 1'b0, 1'b0);  // v2=9  ages end 1
    key_ev(8'h46, 1'b0, 1'b0);  // v3=10 ages end 0
    key_ev(8'h44, 1'b1, 1'b0);  // release D: v2 REL
    key_ev(8'h48, 1'b0, 1'b0);  // H 12 takes REL v2 despite lower age
    checks++; if (voice_note !== {5'd10, 5'd12, 5'd8, 5'd7}) begin errors++; $display("FAIL relpref_note: got %h want %h", voice_note, {5'd10, 5'd12, 5'd8, 5'd7}); end
    checks++; if (steal !== 1'b1) begin errors++; $display("FAIL relpref_steal: got %b want 1", steal); end
    // Ages now v0=4 v1=3 v2=0 v3=1; release v0 and v3, J must pick older v0.
    key_ev(8'h41, 1'b1, 1'b0);
    key_ev(8'h46, 1'b1, 1'b0);
    key_ev(8'h4A, 1'b0, 1'b0);  // J 13
    checks++; if (voice_note !== {5'd10, 5'd12, 5'd8, 5'd13}) begin errors++; $display("FAIL relage_note: got %h want %h", voice_note, {5'd10, 5'd12, 5'd8, 5'd13}); end
    checks++; if (voice_gate !== 4'b0111 || voice_active !== 4'b1111) begin errors++; $display("FAIL relage_gate: gate %b active %b want 0111/1111", voice_gate, voice_active); end
  endtask

  task automatic test_age_saturation();
    do_reset();
    key_ev(8'h41, 1'b0, 1'b0);
    key_ev(8'h53, 1'b0, 1'b0);
    key_ev(8'h44, 1'b0, 1'b0);
    key_ev(8'h46, 1'b0, 1'b0);
    // 13 retriggers of S: v0 saturates at 15 (would wrap to 0), v2=14, v3=13.
    for (int k = 0; k < 13; k++) key_ev(8'h53, 1'b0, 1'b0);
    key_ev(8'h47, 1'b0, 1'b0);  // G 11 steals v0
    checks++; if (voice_note !== {5'd10, 5'd9, 5'd8, 5'd11}) begin errors++; $display("FAIL agesat_note: got %h want %h", voice_note, {5'd10, 5'd9, 5'd8, 5'd11}); end
  endtask

  task automatic test_retrigger();
    do_reset();
    key_ev(8'h51, 1'b0, 1'b0);  // Q -> v0
    key_ev(8'h57, 1'b0, 1'b0);  // W -> v1
    key_ev(8'h51, 1'b1, 1'b0);
    do_tick();
    do_tick();
    key_ev(8'h51, 1'b0, 1'b1);  // re-press Q with a coincident tick
    checks++; if (voice_note !== {R, R, 5'd15, 5'd14}) begin errors++; $display("FAIL retrig_note: got %h want %h", voice_note, {R, R, 5'd15, 5'd14}); end
    checks++; if (voice_gate !== 4'b0011 || voice_active !== 4'b0011) begin errors++; $display("FAIL retrig_gate: gate %b active %b want 0011/0011", voice_gate, voice_active); end
    checks++; if (steal !== 1'b0 || last_note !== 5'd14) begin errors++; $display("FAIL retrig_flags: steal %b last %0d want 0/14", steal, last_note); end
    repeat (8) do_tick();
    checks++; if (voice_active !== 4'b0011) begin errors++; $display("FAIL retrig_hold: active %b want 0011", voice_active); end
    key_ev(8'h57, 1'b1, 1'b0);
    repeat (8) do_tick();
    checks++; if (voice_active !== 4'b0001 || voice_note !== {R, R, R, 5'd14}) begin errors++; $display("FAIL retrig_other_free: active %b note %h", voice_active, voice_note); end
  endtask

  task automatic test_ignore();
    do_reset();
    key_ev(8'h41, 1'b0, 1'b0);
    key_ev(8'h49, 1'b0, 1'b0);  // 'I' unmapped press
    key_ev(8'h49, 1'b1, 1'b0);  // 'I' unmapped release
    key_ev(8'h53, 1'b1, 1'b0);  // release of unheld S
    checks++; if (voice_note !== {R, R, R, 5'd7}) begin errors++; $display("FAIL ignore_note: got %h want %h", voice_note, {R, R, R, 5'd7}); end
    checks++; if (voice_gate !== 4'b0001 || voice_active !== 4'b0001) begin errors++; $display("FAIL ignore_gate: gate %b active %b want 0001/0001", voice_gate, voice_active); end
    checks++; if (last_note !== 5'd7 || steal !== 1'b0) begin errors++; $display("FAIL ignore_last: last %0d steal %b want 7/0", last_note, steal); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    key_valid = 1'b1; key_code = 8'h5A; key_release = 1'b0;  // Z 0
    @(negedge inclk);
    key_code = 8'h58;                                         // X 1
    @(negedge inclk);
    key_valid = 1'b0;
    checks++; if (voice_note !== {R, R, 5'd1, 5'd0}) begin errors++; $display("FAIL b2b_note: got %h want %h", voice_note, {R, R, 5'd1, 5'd0}); end
    checks++; if (last_note !== 5'd1) begin errors++; $display("FAIL b2b_last: got %0d want 1", last_note); end
  endtask

  task automatic test_reset_mid_release();
    do_reset();
    key_ev(8'h51, 1'b0, 1'b0);
    key_ev(8'h51, 1'b1, 1'b0);
    repeat (3) do_tick();
    nCLR = 1'b0;
    @(negedge inclk);
    checks++; if (voice_note !== {R, R, R, R} || voice_active !== 4'b0000) begin errors++; $display("FAIL midrst_voice: note %h active %b", voice_note, voice_active); end
    checks++; if (last_note !== R || voice_gate !== 4'b0000) begin errors++; $display("FAIL midrst_last: last %0d gate %b want 21/0000", last_note, voice_gate); end
    nCLR = 1'b1;
    @(negedge inclk);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_steal_oldest();
    test_release_tail();
    test_steal_rel_pref();
    test_age_saturation();
    test_retrigger();
    test_ignore();
    test_back_to_back();
    test_reset_mid_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
